// File: rtl/tt_sweep_checker.sv
// Sequential truth-table sweeper: steps vec_out through every input vector, samples two
// external boolean functions after a settle window and accumulates their equivalence results.
module tt_sweep_checker #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop_first,
    input  logic                 f_a,
    input  logic                 f_b,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic                 equal,
    output logic [N_IN:0]        mismatch_cnt,
    output logic [N_IN:0]        ones_a,
    output logic [N_IN:0]        ones_b,
    output logic [N_IN-1:0]      first_miss,
    output logic                 first_miss_vld,
    output logic [(1<<N_IN)-1:0] tt_a,
    output logic [(1<<N_IN)-1:0] tt_b
);

    localparam int unsigned NVEC = 1 << N_IN;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StWait   = 2'd1;
    localparam logic [1:0] StSample = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    localparam logic [3:0]      SettleLast = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] VecLast    = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] VecOne     = N_IN'(1);
    localparam logic [N_IN:0]   CntOne     = (N_IN + 1)'(1);
    // With no settle window the sweep goes straight from one sample to the next.
    localparam logic [1:0]      StAfterVec = (SETTLE == 0) ? StSample : StWait;

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            stop_q, stop_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [N_IN-1:0] fm_q, fm_d;
    logic            fmv_q, fmv_d;
    logic            eq_q, eq_d;
    logic [N_IN:0]   mm_q, mm_d;
    logic [N_IN:0]   oa_q, oa_d;
    logic [N_IN:0]   ob_q, ob_d;
    logic [NVEC-1:0] tta_q, tta_d;
    logic [NVEC-1:0] ttb_q, ttb_d;
    logic            miss;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stop_d  = stop_q;
        vec_d   = vec_q;
        fm_d    = fm_q;
        fmv_d   = fmv_q;
        eq_d    = eq_q;
        mm_d    = mm_q;
        oa_d    = oa_q;
        ob_d    = ob_q;
        tta_d   = tta_q;
        ttb_d   = ttb_q;
        miss    = f_a ^ f_b;
        case (state_q)
            StIdle: begin
                if (start) begin
                    tta_d   = '0;
                    ttb_d   = '0;
                    oa_d    = '0;
                    ob_d    = '0;
                    mm_d    = '0;
                    fm_d    = '0;
                    fmv_d   = 1'b0;
                    eq_d    = 1'b0;
                    vec_d   = '0;
                    cnt_d   = '0;
                    stop_d  = stop_first;
                    state_d = StAfterVec;
                end
            end
            StWait: begin
                if (cnt_q == SettleLast) begin
                    cnt_d   = '0;
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StSample: begin
                tta_d[vec_q] = f_a;
                ttb_d[vec_q] = f_b;
                if (f_a) oa_d = oa_q + CntOne;
                if (f_b) ob_d = ob_q + CntOne;
                if (miss) begin
                    mm_d = mm_q + CntOne;
                    if (!fmv_q) begin
                        fm_d  = vec_q;
                        fmv_d = 1'b1;
                    end
                end
                if (vec_q == VecLast || (stop_q && miss)) begin
                    // equal reflects the count including this final sample
                    eq_d    = (mm_d == '0);
                    state_d = StDone;
                end else begin
                    vec_d   = vec_q + VecOne;
                    state_d = StAfterVec;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
            vec_q   <= '0;
            fm_q    <= '0;
            fmv_q   <= 1'b0;
            eq_q    <= 1'b0;
            mm_q    <= '0;
            oa_q    <= '0;
            ob_q    <= '0;
            tta_q   <= '0;
            ttb_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
            vec_q   <= vec_d;
            fm_q    <= fm_d;
            fmv_q   <= fmv_d;
            eq_q    <= eq_d;
            mm_q    <= mm_d;
            oa_q    <= oa_d;
            ob_q    <= ob_d;
            tta_q   <= tta_d;
            ttb_q   <= ttb_d;
        end
    end

    assign vec_out        = vec_q;
    assign busy           = (state_q == StWait) || (state_q == StSample);
    assign done           = (state_q == StDone);
    assign equal          = eq_q;
    assign mismatch_cnt   = mm_q;
    assign ones_a         = oa_q;
    assign ones_b         = ob_q;
    assign first_miss     = fm_q;
    assign first_miss_vld = fmv_q;
    assign tt_a           = tta_q;
    assign tt_b           = ttb_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench for tt_sweep_checker: three configurations (4/1, 4/0, 8/2) driven from
// truth tables, each sweep's expected results computed by a vector-by-vector reference model.
module tb_tt_sweep_checker;

    typedef struct {
        int           inst;
        logic [255:0] tta;
        logic [255:0] ttb;
        int           ones_a;
        int           ones_b;
        int           mm;
        int           fm;
        bit           fmv;
        bit           eq;
        int           vec;
        int           lat;
        int           t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stop_first = 1'b0;
    logic st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
    logic [255:0] ta = '0, tb = '0;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]   v0, v1;
    logic [7:0]   v2;
    logic         busy0, busy1, busy2, done0, done1, done2, eq0, eq1, eq2;
    logic [4:0]   mm0, oa0, ob0, mm1, oa1, ob1;
    logic [8:0]   mm2, oa2, ob2;
    logic [3:0]   fm0, fm1;
    logic [7:0]   fm2;
    logic         fv0, fv1, fv2;
    logic [15:0]  tta0, ttb0, tta1, ttb1;
    logic [255:0] tta2, ttb2;

    tt_sweep_checker #(.N_IN(4), .SETTLE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .stop_first(stop_first),
        .f_a(ta[v0]), .f_b(tb[v0]), .vec_out(v0), .busy(busy0), .done(done0), .equal(eq0),
        .mismatch_cnt(mm0), .ones_a(oa0), .ones_b(ob0), .first_miss(fm0),
        .first_miss_vld(fv0), .tt_a(tta0), .tt_b(ttb0)
    );

    tt_sweep_checker #(.N_IN(4), .SETTLE(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .stop_first(stop_first),
        .f_a(ta[v1]), .f_b(tb[v1]), .vec_out(v1), .busy(busy1), .done(done1), .equal(eq1),
        .mismatch_cnt(mm1), .ones_a(oa1), .ones_b(ob1), .first_miss(fm1),
        .first_miss_vld(fv1), .tt_a(tta1), .tt_b(ttb1)
    );

    tt_sweep_checker #(.N_IN(8), .SETTLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .stop_first(stop_first),
        .f_a(ta[v2]), .f_b(tb[v2]), .vec_out(v2), .busy(busy2), .done(done2), .equal(eq2),
        .mismatch_cnt(mm2), .ones_a(oa2), .ones_b(ob2), .first_miss(fm2),
        .first_miss_vld(fv2), .tt_a(tta2), .tt_b(ttb2)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Walks the vectors in order, exactly as the sweep is meant to visit them.
    function automatic exp_t model(input int id, input logic [255:0] a, input logic [255:0] b,
                                   input bit stop);
        exp_t e;
        int   n;
        int   s;
        int   cnt;
        n = (id == 2) ? 8 : 4;
        s = (id == 0) ? 1 : ((id == 1) ? 0 : 2);
        e.inst = id; e.tta = '0; e.ttb = '0; e.ones_a = 0; e.ones_b = 0; e.mm = 0;
        e.fm = 0; e.fmv = 0; e.vec = 0; e.t0 = 0;
        cnt = 0;
        for (int v = 0; v < (1 << n); v++) begin
            cnt++;
            e.vec = v;
            e.tta[v] = a[v];
            e.ttb[v] = b[v];
            if (a[v]) e.ones_a++;
            if (b[v]) e.ones_b++;
            if (a[v] != b[v]) begin
                if (e.mm == 0) begin
                    e.fm  = v;
                    e.fmv = 1;
                end
                e.mm++;
                if (stop) break;
            end
        end
        e.eq  = (e.mm == 0);
        e.lat = cnt * (s + 1) + 1;
        return e;
    endfunction

    // Latency counts the rising edge at which done is first seen high.
    task automatic check_done(input int id, input logic [255:0] a, input logic [255:0] b,
                              input int oa, input int ob, input int mm, input int fm,
                              input bit fmv, input bit eq, input int vec);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: inst %0d got done=1 required no done", id);
            return;
        end
        e = sb.pop_front();
        chk("done_inst", 256'(id), 256'(e.inst));
        chk("tt_a", a, e.tta);
        chk("tt_b", b, e.ttb);
        chk("ones_a", 256'(oa), 256'(e.ones_a));
        chk("ones_b", 256'(ob), 256'(e.ones_b));
        chk("mismatch_cnt", 256'(mm), 256'(e.mm));
        chk("first_miss_vld", 256'(fmv), 256'(e.fmv));
        if (e.fmv) chk("first_miss", 256'(fm), 256'(e.fm));
        chk("equal", 256'(eq), 256'(e.eq));
        chk("final_vec", 256'(vec), 256'(e.vec));
        chk("latency", 256'(cyc - e.t0 + 1), 256'(e.lat));
    endtask

    always @(negedge clk) begin
        if (done0) check_done(0, {240'b0, tta0}, {240'b0, ttb0}, int'(oa0), int'(ob0),
                              int'(mm0), int'(fm0), fv0, eq0, int'(v0));
        if (done1) check_done(1, {240'b0, tta1}, {240'b0, ttb1}, int'(oa1), int'(ob1),
                              int'(mm1), int'(fm1), fv1, eq1, int'(v1));
        if (done2) check_done(2, tta2, ttb2, int'(oa2), int'(ob2),
                              int'(mm2), int'(fm2), fv2, eq2, int'(v2));
    end

    task automatic start_sweep(input int id, input bit stop, input logic [255:0] a,
                               input logic [255:0] b, input bit push);
        exp_t e;
        @(negedge clk);
        ta = a;
        tb = b;
        stop_first = stop;
        case (id)
            0:       st0 = 1'b1;
            1:       st1 = 1'b1;
            default: st2 = 1'b1;
        endcase
        @(posedge clk);
        #1;
        st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        stop_first = ~stop;
        if (push) begin
            e = model(id, a, b, stop);
            e.t0 = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sweep_timeout: got %0d pending results required 0", sb.size());
            sb.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_inst0_zero(input string tag);
        chk({tag, "_vec"}, 256'(v0), 256'(0));
        chk({tag, "_busy"}, 256'(busy0), 256'(0));
        chk({tag, "_done"}, 256'(done0), 256'(0));
        chk({tag, "_equal"}, 256'(eq0), 256'(0));
        chk({tag, "_counts"}, 256'({mm0, oa0, ob0}), 256'(0));
        chk({tag, "_first"}, 256'({fm0, fv0}), 256'(0));
        chk({tag, "_tt"}, 256'({tta0, ttb0}), 256'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] a, b;
        exp_t         e;
        int           n;

        repeat (3) @(posedge clk);
        #1;
        check_inst0_zero("reset");
        rst_n = 1'b1;

        // XOR of the four bits on both sides.
        start_sweep(0, 0, 256'h6996, 256'h6996, 1);
        wait_idle();
        chk("xor_tt_a", {240'b0, tta0}, 256'h6996);

        // Single planted mismatch at vector 6.
        start_sweep(0, 0, 256'h6996, 256'h69D6, 1);
        wait_idle();
        chk("planted_first_miss", 256'(fm0), 256'(6));
        chk("planted_tt_b", {240'b0, ttb0}, 256'h69D6);

        // Constant 1 against constant 0, early stop.
        start_sweep(0, 1, {256{1'b1}}, 256'h0, 1);
        wait_idle();
        chk("early_stop_vec", 256'(v0), 256'(0));

        // SETTLE=0 instance, vec[0] & ~vec[1].
        start_sweep(1, 0, 256'h2222, 256'h2222, 1);
        wait_idle();
        chk("settle0_ones_a", 256'(oa1), 256'(4));

        // start pulses while busy and in the DONE cycle must be ignored.
        a = rand256();
        b = a ^ rand256();
        e = model(0, a, b, 0);
        start_sweep(0, 0, a, b, 1);
        repeat (5) @(negedge clk);
        st0 = 1'b1;
        @(posedge clk);
        #1;
        st0 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done0 && n < 100);
        st0 = 1'b1;
        @(posedge clk);
        #1;
        st0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("no_restart_busy", 256'(busy0), 256'(0));
            @(posedge clk);
            #1;
        end
        chk("held_mismatch_cnt", 256'(mm0), 256'(e.mm));
        chk("held_ones_a", 256'(oa0), 256'(e.ones_a));
        wait_idle();

        // Reset in the middle of a sweep, then a clean full sweep.
        start_sweep(0, 0, rand256(), rand256(), 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (v0 != 4'd9 && n < 100);
        chk("reached_vec9", 256'(v0), 256'(9));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_inst0_zero("midreset");
        rst_n = 1'b1;
        a = rand256();
        start_sweep(0, 0, a, a ^ 256'h100, 1);
        wait_idle();

        // 8-input instance, f = vec[7].
        start_sweep(2, 0, {{128{1'b1}}, 128'h0}, {{128{1'b1}}, 128'h0}, 1);
        wait_idle();
        chk("n8_ones_a", 256'(oa2), 256'(128));

        for (int it = 0; it < 12; it++) begin
            int id;
            id = int'($urandom_range(0, 2));
            a = rand256();
            case ($urandom_range(0, 2))
                0:       b = a;
                1:       b = a ^ (256'h1 << $urandom_range(0, (id == 2) ? 255 : 15));
                default: b = rand256();
            endcase
            start_sweep(id, bit'($urandom_range(0, 1)), a, b, 1);
            wait_idle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
- Sequential truth-table sweeper and equivalence checker for an N_IN-input boolean function pair, e.g. the full sum-of-minterms form and its minimised form.
- Drives every input vector 0..2^N_IN-1 onto vec_out, waits a settle window, then samples the two external function outputs f_a and f_b.
- Accumulates both truth tables, minterm counts, mismatch count and first failing vector, replacing the unclocked #0 loop used by the display benches.
- Sits in the lab test harness between the vector source and the combinational circuits under comparison.

Parameters:
- N_IN, 4, number of function inputs (legal 1..8).
- SETTLE, 1, idle cycles vec_out is held before sampling (legal 0..15).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin sweep; sampled only in IDLE.
- stop_first  in  1  early-stop mode; latched on accepted start.
- f_a  in  1  output of function A for current vec_out.
- f_b  in  1  output of function B for current vec_out.
- vec_out  out  N_IN  input vector driven to both functions.
- busy  out  1  high in WAIT and SAMPLE.
- done  out  1  one-cycle pulse at end of sweep.
- equal  out  1  valid after done; 1 iff mismatch_cnt==0.
- mismatch_cnt  out  N_IN+1  vectors where f_a!=f_b.
- ones_a  out  N_IN+1  minterms of A.
- ones_b  out  N_IN+1  minterms of B.
- first_miss  out  N_IN  lowest mismatching vector.
- first_miss_vld  out  1  first_miss valid.
- tt_a  out  2^N_IN  captured truth table of A; bit i = f_a at vector i.
- tt_b  out  2^N_IN  captured truth table of B.

Behaviour:
- Reset (rst_n=0 at a rising edge, any state including mid-sweep) sets state to IDLE. All outputs and counters go to 0, and the latched stop_first is cleared.
- States are IDLE, WAIT, SAMPLE, DONE.
- IDLE: on start=1, clear all result outputs, vec_out=0, latch stop_first. Go to WAIT, or straight to SAMPLE if SETTLE==0.
- WAIT: hold vec_out for SETTLE cycles (internal counter), then go to SAMPLE.
- SAMPLE (1 cycle): register f_a and f_b into tt_a[vec_out] and tt_b[vec_out]. Increment ones_a if f_a, ones_b if f_b, and mismatch_cnt if f_a!=f_b.
  - On the first mismatch, load first_miss=vec_out and set first_miss_vld=1.
  - If vec_out==2^N_IN-1, or (latched stop_first and this sample mismatched), go to DONE.
  - Otherwise vec_out+=1 and go to WAIT (or SAMPLE if SETTLE==0).
- DONE (1 cycle): done=1, equal=(mismatch_cnt==0). Go to IDLE; start in this cycle is ignored.
- Latency: each vector occupies SETTLE+1 cycles. A full sweep pulses done (2^N_IN)(SETTLE+1)+1 cycles after the start edge.
- vec_out never wraps: the sweep terminates at the all-ones vector.
- Counters are N_IN+1 bits, so 2^N_IN is representable without overflow.
- start while busy or in DONE is ignored; results are not disturbed.
- Results and vec_out hold their final values in IDLE until the next accepted start or reset.
- equal stays 0 until the first done; in early-stop mode it is 0 whenever done fires on a mismatch.
- f_a and f_b are sampled only in SAMPLE; their values in other cycles have no effect.

Test Plan:
- N_IN=4, SETTLE=1, f_a=f_b=XOR of vec_out bits, stop_first=0 -> done 33 cycles after start; tt_a=tt_b=16'h6996, ones_a=ones_b=8, mismatch_cnt=0, equal=1, first_miss_vld=0.
- Same setup, f_b=f_a XOR (vec_out==4'b0110) -> mismatch_cnt=1, first_miss=6, first_miss_vld=1, equal=0, tt_b=16'h69D6.
- f_a=1, f_b=0, stop_first=1 -> done after one vector (3 cycles); mismatch_cnt=1, first_miss=0, ones_a=1, vec_out=0.
- SETTLE=0, f_a=d AND NOT c (vec_out[0] & ~vec_out[1]), f_b identical -> done 17 cycles after start; ones_a=4, tt_a=16'h2222.
- Pulse start while busy, and again in the DONE cycle -> no restart, counters unchanged. rst_n=0 at vector 9 -> next cycle IDLE, all outputs 0; a later start gives a clean full sweep.
- N_IN=8, SETTLE=2, f_a=f_b=vec_out[7] -> ones_a=128, mismatch_cnt=0, done 769 cycles after start.
